// File: rtl/ds_controller_if.sv
// Signal bundle between the disco/alarm controller and its surroundings.
// The master side drives the switch/sense inputs; the slave side is the controller.
interface ds_controller_if;
    logic       S;
    logic       M;
    logic       L;
    logic       B;
    logic [1:0] STATE;

    modport master (
        output S,
        output M,
        input  L,
        input  B,
        input  STATE
    );

    modport slave (
        input  S,
        input  M,
        output L,
        output B,
        output STATE
    );
endinterface

// File: rtl/ds_controller.sv
// Disco/alarm sequencing controller: synchronizes S and M, debounces M, and
// runs a Moore FSM driving a strobed light L and a time-limited buzzer B.
module ds_controller #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned BLINK_HALF = 8,
    parameter int unsigned HOLD_MIN   = 16,
    parameter int unsigned BUZZ_MAX   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    ds_controller_if.slave  bus
);

    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned DWELL_W = $clog2(HOLD_MIN + 1);
    localparam int unsigned BUZZ_W  = $clog2(BUZZ_MAX + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_SAT  = DWELL_W'(HOLD_MIN);
    localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_MAX - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_LIGHT = 2'b01,
        ST_BUZZ  = 2'b10,
        ST_MUTE  = 2'b11
    } state_t;

    logic               s_meta, s_s;
    logic               m_meta, m_s;
    logic               md;
    logic [DEB_W-1:0]   deb_cnt;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] dwell, dwell_nxt;
    logic [BUZZ_W-1:0]  buzz, buzz_nxt;
    logic [BLINK_W-1:0] blink, blink_nxt;
    logic               phase, phase_nxt;
    logic               l_q, b_q;
    logic               l_nxt, b_nxt;
    logic               entering;

    // Two-flop synchronizers, then M is accepted only after DEB_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta  <= 1'b0;
            s_s     <= 1'b0;
            m_meta  <= 1'b0;
            m_s     <= 1'b0;
            md      <= 1'b0;
            deb_cnt <= '0;
        end else begin
            s_meta <= bus.S;
            s_s    <= s_meta;
            m_meta <= bus.M;
            m_s    <= m_meta;
            if (m_s != md) begin
                if (deb_cnt == DEB_LAST) begin
                    md      <= m_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (!s_s) begin
            state_nxt = ST_OFF;
        end else begin
            unique case (state)
                ST_OFF:   state_nxt = md ? ST_LIGHT : ST_BUZZ;
                ST_LIGHT: if (!md && dwell >= DWELL_SAT) state_nxt = ST_BUZZ;
                ST_BUZZ: begin
                    if (md)                     state_nxt = ST_LIGHT;
                    else if (buzz == BUZZ_LAST) state_nxt = ST_MUTE;
                end
                ST_MUTE:  if (md) state_nxt = ST_LIGHT;
                default:  state_nxt = ST_OFF;
            endcase
        end
    end

    // Every counter restarts on any state change; each only matters while
    // its own state is current, so clearing on exit is harmless.
    always_comb begin
        entering  = (state_nxt != state);
        dwell_nxt = dwell;
        buzz_nxt  = buzz;
        blink_nxt = blink;
        phase_nxt = phase;
        if (entering) begin
            dwell_nxt = '0;
            buzz_nxt  = '0;
            blink_nxt = '0;
            phase_nxt = 1'b1;
        end else begin
            if (state == ST_LIGHT) begin
                if (dwell != DWELL_SAT) dwell_nxt = dwell + 1'b1;
                if (blink == BLINK_LAST) begin
                    blink_nxt = '0;
                    phase_nxt = ~phase;
                end else begin
                    blink_nxt = blink + 1'b1;
                end
            end
            if (state == ST_BUZZ) buzz_nxt = buzz + 1'b1;
        end
        l_nxt = (state_nxt == ST_LIGHT) && phase_nxt;
        b_nxt = (state_nxt == ST_BUZZ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            dwell <= '0;
            buzz  <= '0;
            blink <= '0;
            phase <= 1'b0;
            l_q   <= 1'b0;
            b_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            dwell <= dwell_nxt;
            buzz  <= buzz_nxt;
            blink <= blink_nxt;
            phase <= phase_nxt;
            l_q   <= l_nxt;
            b_q   <= b_nxt;
        end
    end

    assign bus.L     = l_q;
    assign bus.B     = b_q;
    assign bus.STATE = state;

endmodule

// File: tb/tb_ds_controller.sv
// Self-checking bench for ds_controller: a vector table feeds a scoreboard
// queue of per-edge expectations; hand sequences cover asynchronous reset.
module tb_ds_controller;

    localparam logic [1:0] OFF   = 2'b00;
    localparam logic [1:0] LIGHT = 2'b01;
    localparam logic [1:0] BUZZ  = 2'b10;
    localparam logic [1:0] MUTE  = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ds_controller_if bus ();

    ds_controller #(
        .DEB_CYCLES(4),
        .BLINK_HALF(8),
        .HOLD_MIN(16),
        .BUZZ_MAX(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Inputs held for n edges, with the outputs expected after each of those edges.
    typedef struct {
        logic       r;
        logic       s;
        logic       m;
        int         n;
        logic [1:0] st;
        logic       l;
        logic       b;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       l;
        logic       b;
        int         idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic m, input int n,
                                input logic [1:0] st, input logic l, input logic b);
        vec_t v;
        v.r = r; v.s = s; v.m = m; v.n = n; v.st = st; v.l = l; v.b = b;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("vec%0d state/L/B", e.idx), {bus.STATE, bus.L, bus.B}, {e.st, e.l, e.b});
            check($sformatf("vec%0d L&B exclusive", e.idx), {3'b000, bus.L & bus.B}, 4'b0000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.S = 1'b0;
        bus.M = 1'b0;

        // Reset, then S=1/M=0: BUZZ for 32 cycles, then MUTE for 100.
        tbl.push_back(mk(0, 1, 0,   1, OFF,   0, 0));
        tbl.push_back(mk(1, 1, 0,   2, OFF,   0, 0));
        tbl.push_back(mk(1, 1, 0,  32, BUZZ,  0, 1));
        tbl.push_back(mk(1, 1, 0, 100, MUTE,  0, 0));
        // 3-cycle glitch in MUTE is filtered.
        tbl.push_back(mk(1, 1, 1,   3, MUTE,  0, 0));
        tbl.push_back(mk(1, 1, 0,  10, MUTE,  0, 0));
        // 4-cycle pulse wakes LIGHT at edge 7; hold keeps LIGHT until dwell 16.
        tbl.push_back(mk(1, 1, 1,   4, MUTE,  0, 0));
        tbl.push_back(mk(1, 1, 0,   2, MUTE,  0, 0));
        tbl.push_back(mk(1, 1, 0,   8, LIGHT, 1, 0));
        tbl.push_back(mk(1, 1, 0,   8, LIGHT, 0, 0));
        tbl.push_back(mk(1, 1, 0,   1, LIGHT, 1, 0));
        // BUZZ; M back so Md=1 exactly when buzz count is 31 -> LIGHT not MUTE.
        tbl.push_back(mk(1, 1, 0,  26, BUZZ,  0, 1));
        tbl.push_back(mk(1, 1, 1,   6, BUZZ,  0, 1));
        tbl.push_back(mk(1, 1, 1,   4, LIGHT, 1, 0));
        // S dropped at dwell 3 overrides the hold.
        tbl.push_back(mk(1, 0, 1,   2, LIGHT, 1, 0));
        tbl.push_back(mk(1, 0, 1,   3, OFF,   0, 0));
        // Reset, then S=1/M=1: BUZZ at edge 3, LIGHT at edge 7, strobe 8/8/8.
        tbl.push_back(mk(0, 1, 1,   1, OFF,   0, 0));
        tbl.push_back(mk(1, 1, 1,   2, OFF,   0, 0));
        tbl.push_back(mk(1, 1, 1,   4, BUZZ,  0, 1));
        tbl.push_back(mk(1, 1, 1,   8, LIGHT, 1, 0));
        tbl.push_back(mk(1, 1, 1,   8, LIGHT, 0, 0));
        tbl.push_back(mk(1, 1, 1,   8, LIGHT, 1, 0));
        tbl.push_back(mk(1, 0, 1,   2, LIGHT, 0, 0));
        tbl.push_back(mk(1, 0, 0,   3, OFF,   0, 0));

        @(negedge clk);
        check("reset state", {bus.STATE, bus.L, bus.B}, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                @(negedge clk);
                rst_n = tbl[i].r;
                bus.S = tbl[i].s;
                bus.M = tbl[i].m;
                @(posedge clk);
                e.st = tbl[i].st; e.l = tbl[i].l; e.b = tbl[i].b; e.idx = i;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of BUZZ, between clock edges.
        rst_n = 1'b0;
        bus.S = 1'b1;
        bus.M = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("pre-reset BUZZ", {bus.STATE, bus.L, bus.B}, {BUZZ, 1'b0, 1'b1});
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset", {bus.STATE, bus.L, bus.B}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) check($sformatf("release edge%0d", k), {bus.STATE, bus.L, bus.B}, 4'b0000);
            else       check("release edge3", {bus.STATE, bus.L, bus.B}, {BUZZ, 1'b0, 1'b1});
        end
        bus.S = 1'b0;
        repeat (4) @(negedge clk);
        check("S low final", {bus.STATE, bus.L, bus.B}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
